// File: rtl/control_estacionamiento.sv
// Parking-lot occupancy counter and entry-barrier sequencer.
// Counts cars from detector pulses and opens the barrier on request, with a no-show timeout and a post-entry hold.
module control_estacionamiento #(
    parameter int  CAPACITY    = 16,
    parameter int  OPEN_CYCLES = 50,
    parameter int  HOLD_CYCLES = 10,
    localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pedido,
    input  logic             entrada,
    input  logic             salida,
    output logic [CNT_W-1:0] ocupacion,
    output logic             lleno,
    output logic             vacio,
    output logic             barrera,
    output logic             rechazo,
    output logic             timeout,
    output logic             error
);

    localparam int MAX_T = (OPEN_CYCLES > HOLD_CYCLES) ? OPEN_CYCLES : HOLD_CYCLES;
    localparam int TMR_W = $clog2(MAX_T);
    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        CERRADA = 2'd0,
        ABIERTA = 2'd1,
        ESPERA  = 2'd2
    } estado_t;

    estado_t          state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] ocupacion_q, ocupacion_d;
    logic             barrera_q, barrera_d;
    logic             timeout_q, timeout_d;
    logic             error_q, error_d;

    assign ocupacion = ocupacion_q;
    assign barrera   = barrera_q;
    assign timeout   = timeout_q;
    assign error     = error_q;
    assign lleno     = (ocupacion_q == CAP_VAL);
    assign vacio     = (ocupacion_q == '0);
    assign rechazo   = (state_q == CERRADA) && pedido && lleno;

    // Simultaneous entrada and salida cancel out, even at the count limits.
    always_comb begin
        ocupacion_d = ocupacion_q;
        error_d     = error_q;
        if (entrada && !salida) begin
            if (!lleno) ocupacion_d = ocupacion_q + CNT_W'(1);
            else        error_d     = 1'b1;
        end else if (salida && !entrada) begin
            if (!vacio) ocupacion_d = ocupacion_q - CNT_W'(1);
            else        error_d     = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        case (state_q)
            CERRADA: begin
                if (pedido && !lleno) begin
                    state_d = ABIERTA;
                    timer_d = '0;
                end
            end
            ABIERTA: begin
                timer_d = timer_q + TMR_W'(1);
                if (entrada) begin
                    state_d = ESPERA;
                    timer_d = '0;
                end else if (timer_q == OPEN_LAST) begin
                    state_d   = CERRADA;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            ESPERA: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == HOLD_LAST) begin
                    state_d = CERRADA;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = CERRADA;
                timer_d = '0;
            end
        endcase
        // Registered from the next state so barrera is a clean flop output.
        barrera_d = (state_d != CERRADA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CERRADA;
            timer_q     <= '0;
            ocupacion_q <= '0;
            barrera_q   <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ocupacion_q <= ocupacion_d;
            barrera_q   <= barrera_d;
            timeout_q   <= timeout_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_control_estacionamiento.sv
// Self-checking bench for control_estacionamiento: directed table, corner sequences and random stimulus vs a countdown model.
module tb_control_estacionamiento;

    localparam int CAP  = 3;
    localparam int OPEN = 8;
    localparam int HOLD = 4;
    localparam int CW   = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pedido, entrada, salida;
    logic [CW-1:0] ocupacion;
    logic          lleno, vacio, barrera, rechazo, timeout, error;

    int n_checks = 0;
    int n_errors = 0;

    // Model: barrier described by how many cycles it stays open, plus whether it still waits for a car.
    int m_occ;
    bit m_err;
    int m_left;
    bit m_wait;
    bit m_to;
    bit m_ped;

    control_estacionamiento #(
        .CAPACITY   (CAP),
        .OPEN_CYCLES(OPEN),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pedido   (pedido),
        .entrada  (entrada),
        .salida   (salida),
        .ocupacion(ocupacion),
        .lleno    (lleno),
        .vacio    (vacio),
        .barrera  (barrera),
        .rechazo  (rechazo),
        .timeout  (timeout),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ped;
        bit ent;
        bit sal;
        int oc;
        bit bar;
        bit to;
        bit err;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_err = 0; m_left = 0; m_wait = 0; m_to = 0; m_ped = 0;
    endtask

    task automatic model_edge(input bit ped, input bit ent, input bit sal);
        bit full;
        full = (m_occ == CAP);
        if (ent && !sal) begin
            if (m_occ < CAP) m_occ++; else m_err = 1;
        end else if (sal && !ent) begin
            if (m_occ > 0) m_occ--; else m_err = 1;
        end
        m_to = 0;
        if (m_left == 0) begin
            if (ped && !full) begin
                m_left = OPEN;
                m_wait = 1;
            end
        end else if (m_wait && ent) begin
            m_left = HOLD;
            m_wait = 0;
        end else begin
            m_left--;
            if (m_left == 0 && m_wait) begin
                m_to   = 1;
                m_wait = 0;
            end
        end
        m_ped = ped;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".ocupacion"}, int'(ocupacion), m_occ);
        check({tag, ".lleno"},     int'(lleno),     int'(m_occ == CAP));
        check({tag, ".vacio"},     int'(vacio),     int'(m_occ == 0));
        check({tag, ".barrera"},   int'(barrera),   int'(m_left > 0));
        check({tag, ".rechazo"},   int'(rechazo),   int'(m_left == 0 && m_ped && m_occ == CAP));
        check({tag, ".timeout"},   int'(timeout),   int'(m_to));
        check({tag, ".error"},     int'(error),     int'(m_err));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit ped, input bit ent, input bit sal, input string tag);
        pedido  = ped;
        entrada = ent;
        salida  = sal;
        @(posedge clk);
        model_edge(ped, ent, sal);
        #1;
        compare_model(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        pedido  = 1'b0;
        entrada = 1'b0;
        salida  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 1, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 1, 0, 0};
        tbl[3] = '{0, 1, 0, 1, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 1, 1, 0, 0};
        tbl[5] = '{0, 0, 0, 1, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 1, 1, 0, 0};
        tbl[7] = '{0, 0, 0, 1, 0, 0, 0};
        tbl[8] = '{1, 0, 0, 1, 1, 0, 0};
        for (int i = 9; i <= 15; i++) tbl[i] = '{0, 0, 0, 1, 1, 0, 0};
        tbl[16] = '{0, 0, 0, 1, 0, 1, 0};
        tbl[17] = '{0, 0, 0, 1, 0, 0, 0};

        // Reset held with pedido high: outputs at reset values.
        rst_n   = 1'b0;
        pedido  = 1'b1;
        entrada = 1'b0;
        salida  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst.ocupacion", int'(ocupacion), 0);
        check("rst.barrera",   int'(barrera),   0);
        check("rst.vacio",     int'(vacio),     1);
        check("rst.lleno",     int'(lleno),     0);
        check("rst.rechazo",   int'(rechazo),   0);
        check("rst.timeout",   int'(timeout),   0);
        check("rst.error",     int'(error),     0);
        rst_n = 1'b1;

        // Directed table: one car with hold, then a no-show timeout.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].ped, tbl[i].ent, tbl[i].sal, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.oc", i),  int'(ocupacion), tbl[i].oc);
            check($sformatf("tbl%0d.bar", i), int'(barrera),   int'(tbl[i].bar));
            check($sformatf("tbl%0d.to", i),  int'(timeout),   int'(tbl[i].to));
            check($sformatf("tbl%0d.err", i), int'(error),     int'(tbl[i].err));
        end

        // Fill the lot, then refused request and overflow error.
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0, "fill_req");
            step(0, 1, 0, "fill_ent");
            for (int j = 0; j < HOLD; j++) step(0, 0, 0, "fill_hold");
        end
        check("full.lleno", int'(lleno), 1);
        check("full.ocup",  int'(ocupacion), 3);
        check("full.bar",   int'(barrera), 0);
        step(1, 0, 0, "reject");
        check("reject.rechazo", int'(rechazo), 1);
        check("reject.barrera", int'(barrera), 0);
        step(1, 0, 0, "reject2");
        check("reject2.barrera", int'(barrera), 0);
        step(0, 1, 0, "overflow");
        check("overflow.ocup",  int'(ocupacion), 3);
        check("overflow.error", int'(error), 1);
        step(0, 0, 0, "overflow_sticky");
        check("overflow_sticky.error", int'(error), 1);

        // Underflow at zero.
        do_reset();
        step(0, 0, 1, "underflow");
        check("underflow.ocup",  int'(ocupacion), 0);
        check("underflow.error", int'(error), 1);

        // Simultaneous pulses at two cars; closed-barrier entries still count.
        do_reset();
        step(0, 1, 0, "unauth1");
        step(0, 1, 0, "unauth2");
        step(0, 1, 1, "both");
        check("both.ocup",  int'(ocupacion), 2);
        check("both.error", int'(error), 0);

        // Asynchronous reset during hold at timer=2.
        do_reset();
        step(1, 0, 0, "ar_req");
        step(0, 1, 0, "ar_ent");
        step(0, 0, 0, "ar_h1");
        step(0, 0, 0, "ar_h2");
        check("ar_pre.barrera", int'(barrera), 1);
        rst_n = 1'b0;
        #1;
        check("ar_async.barrera", int'(barrera), 0);
        check("ar_async.ocup",    int'(ocupacion), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, "ar_after");
        check("ar_after.barrera", int'(barrera), 0);
        step(1, 0, 0, "ar_reopen");
        check("ar_reopen.barrera", int'(barrera), 1);

        // Random stimulus against the model, with periodic resets to clear sticky error.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                step($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 6) == 0, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
